// File: rtl/triple_rotate_stage.sv
// triple_rotate_stage
//   Collects three words (a, b, c) from a serial valid/ready stream, rotates
//   the triple a programmable number of times (a<=b, b<=c, c<=a, all updated
//   together), then presents the result on a valid/ready output port.
//   The rotation count is sampled only with word a.

module triple_rotate_stage #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [CNT_W-1:0] rot_count,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [WIDTH-1:0] out_c,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_ROTATE = 2'd1,
        ST_OUT    = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       idx_q, idx_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] c_q, c_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A word is consumed only while loading; in_valid elsewhere is ignored.
    logic word_take;
    assign word_take = (state_q == ST_LOAD) && in_valid;

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // its pre-edge value; this is also what makes the a/b/c rotation simultaneous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: LOAD -> (ROTATE) -> OUT -> LOAD.
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_LOAD: begin
                if (word_take && (idx_q == 2'd2)) begin
                    state_d = (cnt_q != '0) ? ST_ROTATE : ST_OUT;
                end
            end
            ST_ROTATE: begin
                // The edge that takes the count from 1 to 0 is the last rotation.
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    // Datapath next-state: word assembly, rotation and count decrement.
    always_comb begin
        idx_d = idx_q;
        a_d   = a_q;
        b_d   = b_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        unique case (state_q)
            ST_LOAD: begin
                if (word_take) begin
                    unique case (idx_q)
                        2'd0: begin
                            a_d   = in_data;
                            cnt_d = rot_count;
                        end
                        2'd1:    b_d = in_data;
                        default: c_d = in_data;
                    endcase
                    idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
                end
            end
            ST_ROTATE: begin
                a_d   = b_q;
                b_d   = c_q;
                c_d   = a_q;
                cnt_d = cnt_q - CNT_W'(1);
            end
            ST_OUT: begin
                if (out_ready) begin
                    idx_d = 2'd0;
                end
            end
            default: idx_d = 2'd0;
        endcase
    end

    // Datapath registers; reset discards any partial or in-flight triple.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= 2'd0;
            a_q   <= '0;
            b_q   <= '0;
            c_q   <= '0;
            cnt_q <= '0;
        end else begin
            idx_q <= idx_d;
            a_q   <= a_d;
            b_q   <= b_d;
            c_q   <= c_d;
            cnt_q <= cnt_d;
        end
    end

    // Outputs decoded from state; the triple is exposed only while offered.
    always_comb begin
        in_ready  = (state_q == ST_LOAD);
        busy      = (state_q != ST_LOAD);
        out_valid = (state_q == ST_OUT);
        out_a     = '0;
        out_b     = '0;
        out_c     = '0;
        if (state_q == ST_OUT) begin
            out_a = a_q;
            out_b = b_q;
            out_c = c_q;
        end
    end

endmodule
